// File: rtl/sum_result_fifo_pkg.sv
// Shared constants and types for the running-sum result FIFO.
package sum_result_fifo_pkg;

  localparam int SUM_FIFO_WIDTH = 32;
  localparam int SUM_FIFO_DEPTH = 8;
  localparam int SUM_FIFO_AW    = 3;
  localparam int DROP_CNT_W     = 16;

  typedef logic [SUM_FIFO_WIDTH-1:0] sum_word_t;
  typedef logic [DROP_CNT_W-1:0]     drop_cnt_t;

endpackage

// File: rtl/sum_result_fifo_if.sv
// Producer/consumer handshake bundle of the running-sum result FIFO.
interface sum_result_fifo_if;
  import sum_result_fifo_pkg::*;

  sum_word_t in_data;
  logic      in_valid;
  sum_word_t out_data;
  logic      out_valid;
  logic      out_ready;

  // FIFO side
  modport slave (
    input  in_data,
    input  in_valid,
    output out_data,
    output out_valid,
    input  out_ready
  );

  // Adding machine / consumer side
  modport master (
    output in_data,
    output in_valid,
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/sum_fifo_mem.sv
// DEPTH x 32 register file: one synchronous write port, one asynchronous read port.
module sum_fifo_mem
  import sum_result_fifo_pkg::*;
#(
    parameter int DEPTH = SUM_FIFO_DEPTH,
    parameter int AW    = SUM_FIFO_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  sum_word_t     wdata,
    input  logic [AW-1:0] raddr,
    output sum_word_t     rdata
);

    sum_word_t mem [DEPTH];

    // NOTE: storage has no reset; validity is tracked by the pointers, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sum_result_fifo.sv
// Show-ahead FIFO buffering the adding machine's running sum for a stallable consumer.
// Optional: define SUM_FIFO_DROP_COUNT_EN to add the saturating drop_count port.
module sum_result_fifo
  import sum_result_fifo_pkg::*;
#(
    parameter int DEPTH = SUM_FIFO_DEPTH,
    parameter int AW    = SUM_FIFO_AW
) (
    input  logic                clk,
    input  logic                reset,
    sum_result_fifo_if.slave    bus,
    output logic [AW:0]         count,
    output logic                full,
    output logic                dropped
`ifdef SUM_FIFO_DROP_COUNT_EN
    ,
    output drop_cnt_t           drop_count
`endif
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push;
    logic        pop;
    logic        drop;

    // Flags come straight from the registered pointers, never from this cycle's push/pop.
    assign bus.out_valid = (wr_ptr != rd_ptr);
    assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign pop  = bus.out_valid & bus.out_ready;
    assign push = bus.in_valid & (~full | pop);
    assign drop = bus.in_valid & full & ~pop;

    sum_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.in_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (bus.out_data)
    );

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            dropped <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + PTR_ONE;
            end else if (pop && !push) begin
                count <= count - PTR_ONE;
            end
            if (drop) begin
                dropped <= 1'b1;
            end
        end
    end

`ifdef SUM_FIFO_DROP_COUNT_EN
    localparam drop_cnt_t DROP_MAX = '1;
    localparam drop_cnt_t DROP_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (drop && (drop_count != DROP_MAX)) begin
            drop_count <= drop_count + DROP_ONE;
        end
    end
`endif

endmodule
